// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer: owns state/key registers, round counter and handshakes
// around external round and final-round datapaths. Optional AES_ABORT_EN adds an abort input.
module aes_round_ctrl #(
   parameter int NR = 10,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
`ifdef AES_ABORT_EN
   input  logic          abort,
`endif
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [127:0]  pt_in,
   input  logic [127:0]  key_in,
   output logic [CW-1:0] rnd_count,
   output logic [127:0]  rnd_data,
   output logic [127:0]  rnd_key,
   input  logic [127:0]  rnd_out,
   input  logic [127:0]  rnd_keyout,
   input  logic [127:0]  last_out,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [127:0]  ct_out,
   output logic          busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DONE} state_t;

   localparam logic [CW-1:0] LP_LASTRUN = CW'(NR - 1);

   state_t        r_state;
   logic [127:0]  r_blk;
   logic [127:0]  r_key;
   logic [CW-1:0] r_cnt;
   logic          r_in_ready;
   logic          r_out_valid;
   logic [127:0]  r_ct;
   logic          r_busy;
   logic          w_abort;

`ifdef AES_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_blk       <= '0;
         r_key       <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_ct        <= '0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_blk      <= pt_in ^ key_in;
                  r_key      <= key_in;
                  r_cnt      <= CW'(1);
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_abort) begin
                  r_blk      <= '0;
                  r_key      <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end else begin
                  r_blk <= rnd_out;
                  r_key <= rnd_keyout;
                  r_cnt <= r_cnt + CW'(1);
                  if (r_cnt == LP_LASTRUN) r_state <= S_LAST;
               end
            end
            S_LAST: begin
               // key_reg still holds round key NR-1; the datapath supplies key NR
               if (w_abort) begin
                  r_blk      <= '0;
                  r_key      <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end else begin
                  r_ct        <= last_out;
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               // in_ready rises only after the handshake edge, so no same-cycle re-accept
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_cnt       <= '0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign ct_out    = r_ct;
   assign busy      = r_busy;
   assign rnd_count = r_busy ? r_cnt : '0;
   assign rnd_data  = r_blk;
   assign rnd_key   = r_key;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: attaches behavioural AES round logic and checks
// sequencing, backpressure, reset, back-to-back and (with AES_ABORT_EN) abort.
module tb_aes_round_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready;
   logic [127:0] pt_in, key_in;
   logic [3:0]   rnd_count;
   logic [127:0] rnd_data, rnd_key, rnd_out, rnd_keyout, last_out;
   logic         out_valid, out_ready;
   logic [127:0] ct_out;
   logic         busy;
`ifdef AES_ABORT_EN
   logic         abort = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int lat;

   always #5 clk = ~clk;

   aes_round_ctrl #(.NR(10), .CW(4)) dut (
      .clk(clk), .rst(rst),
`ifdef AES_ABORT_EN
      .abort(abort),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .pt_in(pt_in), .key_in(key_in),
      .rnd_count(rnd_count), .rnd_data(rnd_data), .rnd_key(rnd_key),
      .rnd_out(rnd_out), .rnd_keyout(rnd_keyout), .last_out(last_out),
      .out_valid(out_valid), .out_ready(out_ready), .ct_out(ct_out), .busy(busy)
   );

   // ---------------- AES arithmetic ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   // multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq = a;
      logic [7:0] r  = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] gb(input logic [127:0] s, input int i);
      return s[127-8*i -: 8];
   endfunction

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = sbox(gb(s, 4*((c+r)%4)+r));
      return o;
   endfunction

   function automatic logic [127:0] mixcols(input logic [127:0] s);
      logic [127:0] o = '0;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
         o[127-32*c -: 32] = {gmul(a0,2)^gmul(a1,3)^a2^a3, a0^gmul(a1,2)^gmul(a2,3)^a3,
                              a0^a1^gmul(a2,2)^gmul(a3,3), gmul(a0,3)^a1^a2^gmul(a3,2)};
      end
      return o;
   endfunction

   function automatic logic [7:0] rcon(input int i);
      logic [7:0] r = 8'h01;
      for (int j = 1; j < i; j++) r = xt(r);
      return r;
   endfunction

   function automatic logic [127:0] keyexp(input logic [127:0] k, input int i);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = k;
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon(i), 24'h0};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // whole-block reference encryption
   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      logic [127:0] s = pt ^ key;
      logic [127:0] k = key;
      for (int r = 1; r <= 10; r++) begin
         k = keyexp(k, r);
         s = sub_shift(s);
         if (r < 10) s = mixcols(s);
         s = s ^ k;
      end
      return s;
   endfunction

   // attached round / final-round datapaths
   assign rnd_keyout = keyexp(rnd_key, int'(rnd_count));
   assign rnd_out    = mixcols(sub_shift(rnd_data)) ^ rnd_keyout;
   assign last_out   = sub_shift(rnd_data) ^ rnd_keyout;

   // ---------------- bench helpers ----------------
   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic start(input logic [127:0] pt, input logic [127:0] key, input bit keep);
      int t = 0;
      pt_in = pt; key_in = key; in_valid = 1'b1;
      while (!in_ready && t < 30) begin tick; t++; end
      chk("accept_ready", 128'(in_ready), 128'd1);
      tick;
      if (!keep) in_valid = 1'b0;
      lat = 1;
   endtask

   task automatic finish_enc(input int hold, input bit keep, output logic [127:0] ct);
      while (!out_valid && lat < 40) begin tick; lat++; end
      if (!keep) in_valid = 1'b0;
      ct = ct_out;
      for (int h = 0; h < hold; h++) begin
         tick;
         chk("hold_ct", ct_out, ct);
         chk("hold_valid", 128'(out_valid), 128'd1);
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("post_hs_valid", 128'(out_valid), 128'd0);
      chk("post_hs_ready", 128'(in_ready), 128'd1);
   endtask

   typedef struct {
      logic [127:0] pt;
      logic [127:0] key;
      logic [127:0] ct;
   } vec_t;

   vec_t tbl[3];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] ct, ct1, pt, key;
      int busyc, seen;

      tbl[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      tbl[1] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
      tbl[2] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                 128'h3925841d02dc09fbdc118597196a0b32};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pt_in = '0; key_in = '0;
      tick; tick;
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_ct", ct_out, 128'd0);
      chk("rst_rnd_count", 128'(rnd_count), 128'd0);
      chk("rst_rnd_data", rnd_data, 128'd0);
      chk("rst_rnd_key", rnd_key, 128'd0);
      #3 rst = 1'b0;
      tick;

      // table-driven known-answer vectors
      for (int i = 0; i < 3; i++) begin
         start(tbl[i].pt, tbl[i].key, 1'b0);
         finish_enc(2, 1'b0, ct);
         chk($sformatf("kat%0d_ct", i), ct, tbl[i].ct);
         chk($sformatf("kat%0d_lat", i), 128'(lat), 128'd11);
      end

      // round index / busy sequence and 5-cycle backpressure
      start(tbl[0].pt, tbl[0].key, 1'b0);
      busyc = 0;
      for (int k = 1; k <= 11; k++) begin
         chk($sformatf("seq_cnt_c%0d", k), 128'(rnd_count), (k <= 10) ? 128'(k) : 128'd0);
         busyc += int'(busy);
         if (k < 11) begin tick; lat++; end
      end
      chk("seq_busy_cycles", 128'(busyc), 128'd10);
      chk("seq_done_valid", 128'(out_valid), 128'd1);
      finish_enc(5, 1'b0, ct);
      chk("seq_ct", ct, tbl[0].ct);

      // in_valid with all-ones plaintext during RUN is ignored
      start(tbl[0].pt, tbl[0].key, 1'b0);
      tick; tick; tick; lat += 3;
      pt_in = '1; in_valid = 1'b1;
      chk("ign_ready_low", 128'(in_ready), 128'd0);
      finish_enc(1, 1'b0, ct);
      chk("ign_ct", ct, tbl[0].ct);
      tick;
      chk("ign_idle", 128'(busy), 128'd0);

      // asynchronous reset in RUN cycle 4
      start(tbl[2].pt, tbl[2].key, 1'b0);
      tick; tick; tick;
      #2 rst = 1'b1;
      #1;
      chk("arst_in_ready", 128'(in_ready), 128'd1);
      chk("arst_out_valid", 128'(out_valid), 128'd0);
      chk("arst_busy", 128'(busy), 128'd0);
      chk("arst_ct", ct_out, 128'd0);
      chk("arst_rnd_count", 128'(rnd_count), 128'd0);
      chk("arst_rnd_data", rnd_data, 128'd0);
      chk("arst_rnd_key", rnd_key, 128'd0);
      #2 rst = 1'b0;
      tick;
      start(tbl[0].pt, tbl[0].key, 1'b0);
      finish_enc(0, 1'b0, ct);
      chk("arst_next_ct", ct, tbl[0].ct);
      chk("arst_next_lat", 128'(lat), 128'd11);

      // back-to-back with in_valid held high
      start(tbl[0].pt, tbl[0].key, 1'b1);
      pt_in = tbl[1].pt; key_in = tbl[1].key;
      finish_enc(1, 1'b1, ct1);
      chk("b2b_first_ct", ct1, tbl[0].ct);
      chk("b2b_not_same_cycle", 128'(busy), 128'd0);
      tick;
      chk("b2b_accepted_busy", 128'(busy), 128'd1);
      chk("b2b_accepted_ready", 128'(in_ready), 128'd0);
      in_valid = 1'b0;
      lat = 1;
      finish_enc(0, 1'b0, ct);
      chk("b2b_second_ct", ct, tbl[1].ct);
      chk("b2b_second_lat", 128'(lat), 128'd11);

      // randomized vectors against the reference model
      for (int i = 0; i < 8; i++) begin
         pt  = {$urandom, $urandom, $urandom, $urandom};
         key = {$urandom, $urandom, $urandom, $urandom};
         start(pt, key, 1'b0);
         finish_enc(int'($urandom_range(0, 3)), 1'b0, ct);
         chk($sformatf("rand%0d_ct", i), ct, aes_ref(pt, key));
         chk($sformatf("rand%0d_lat", i), 128'(lat), 128'd11);
      end

`ifdef AES_ABORT_EN
      // abort in RUN cycle 6
      start(tbl[2].pt, tbl[2].key, 1'b0);
      for (int k = 0; k < 5; k++) tick;
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("abort_in_ready", 128'(in_ready), 128'd1);
      chk("abort_busy", 128'(busy), 128'd0);
      chk("abort_rnd_data", rnd_data, 128'd0);
      chk("abort_rnd_key", rnd_key, 128'd0);
      chk("abort_rnd_count", 128'(rnd_count), 128'd0);
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         seen += int'(out_valid);
         tick;
      end
      chk("abort_no_valid", 128'(seen), 128'd0);
      start(tbl[0].pt, tbl[0].key, 1'b0);
      finish_enc(0, 1'b0, ct);
      chk("abort_next_ct", ct, tbl[0].ct);
`else
      seen = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer that time-multiplexes one round datapath and one final-round datapath.
- The round datapath performs KeyGeneration, SubBytes, ShiftRows, MixColumns and AddRoundKey. The final-round datapath performs SubBytes, ShiftRows and AddRoundKey, with no MixColumns.
- Owns the state and key registers, the round counter and the valid/ready handshakes.
- Sits between the block-level input and output interfaces and the combinational round logic.

Parameters:
- NR, 10, total number of rounds; the last one is the final round.
- CW, 4, round counter width; must satisfy 2^CW > NR.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  plaintext and key are present.
- in_ready  output  1  block can accept a new plaintext/key pair.
- pt_in  input  128  plaintext.
- key_in  input  128  cipher key.
- rnd_count  output  CW  round index to the round datapath (drives r_count).
- rnd_data  output  128  current state register value.
- rnd_key  output  128  current key register value, i.e. the previous round key.
- rnd_out  input  128  round datapath result (rndout).
- rnd_keyout  input  128  next round key from the round datapath (keyout).
- last_out  input  128  final-round datapath result, computed from rnd_data and rnd_keyout.
- out_valid  output  1  ciphertext is valid.
- out_ready  input  1  consumer accepts the ciphertext.
- ct_out  output  128  ciphertext.
- busy  output  1  high in RUN or LAST.

Behaviour:
- States: IDLE, RUN, LAST, DONE.
- Reset (async, any state) forces:
  - state IDLE;
  - state_reg = 0, key_reg = 0, cnt = 0;
  - in_ready = 1, out_valid = 0, ct_out = 0, busy = 0.
- IDLE: in_ready = 1.
  - On in_valid: state_reg <= pt_in ^ key_in, key_reg <= key_in, cnt <= 1, go to RUN.
- RUN: in_ready = 0, busy = 1, rnd_count = cnt.
  - Each cycle: state_reg <= rnd_out, key_reg <= rnd_keyout, cnt <= cnt + 1.
  - When cnt == NR-1 at the clock edge, go to LAST. cnt becomes NR.
- LAST: rnd_count = NR, busy = 1.
  - ct_out <= last_out, out_valid <= 1, go to DONE.
  - key_reg and state_reg are left unchanged.
- DONE: out_valid = 1 and ct_out is held stable until out_ready = 1.
  - On acceptance: out_valid <= 0, cnt <= 0, go to IDLE. in_ready is 1 on the following cycle.
  - No back-to-back bypass: a new request cannot be accepted in the same cycle the output is accepted.
- Latency: the accept edge is cycle 0.
  - RUN occupies cycles 1..NR-1 (9 cycles for NR = 10).
  - LAST is cycle NR.
  - out_valid rises after the LAST edge, NR+1 = 11 edges after accept.
- rnd_count is 0 whenever the block is in IDLE or DONE.
- rnd_data and rnd_key always equal the register contents, including in IDLE and DONE.
- in_valid outside IDLE is ignored; no input is captured.
- Reset mid-operation aborts immediately with no output. The next accept starts cleanly.
- The counter never wraps: cnt stays in 0..NR.

Optional Feature:
- Macro AES_ABORT_EN.
- When defined, adds input `abort` (1 bit).
  - abort = 1 in RUN or LAST returns the block to IDLE on the next edge.
  - State_reg, key_reg and cnt are cleared to 0 and out_valid stays 0.
  - abort in IDLE or DONE is ignored.
- When undefined, there is no abort port and a started operation always completes.

Test Plan:
- FIPS-197 vector: pt = 00112233445566778899aabbccddeeff, key = 000102030405060708090a0b0c0d0e0f with real round and final-round logic attached → ct_out = 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid rising 11 edges after accept.
- Sequencing and backpressure:
  - rnd_count sequence is 1..10 across cycles 1..10 and returns to 0 in DONE.
  - busy is high in exactly 10 cycles.
  - Hold out_ready = 0 for 5 cycles: ct_out and out_valid stay stable.
  - Raise out_ready: out_valid falls and in_ready rises on the next cycle.
- in_valid with pt = all ones asserted during RUN → ignored; the original ciphertext is unchanged.
- Assert rst asynchronously mid-clock at cycle 4 of RUN → all outputs reach their reset values immediately. The next vector still produces the correct ciphertext.
- Two vectors back-to-back with in_valid held high → the second is accepted exactly one cycle after the first output handshake. Both ciphertexts are correct (second vector: key all zeros, pt all zeros → 66e94bd4ef8a2c3b884cfa59ca342b2e).
- AES_ABORT_EN: pulse abort at cycle 6 → IDLE next cycle, out_valid never set, and the following vector is encrypted correctly.
